// File: rtl/lbs_wave_regs_pkg.sv
`timescale 1ns/1ps
// Shared constants and the address decoder for the wave-path register slave.
package lbs_wave_regs_pkg;

  localparam int unsigned N_EVT = 4;

  localparam logic [15:0] OFS_VERSION    = 16'h0000;
  localparam logic [15:0] OFS_SCRATCH    = 16'h0004;
  localparam logic [15:0] OFS_CTRL       = 16'h0008;
  localparam logic [15:0] OFS_LED_PERIOD = 16'h000C;
  localparam logic [15:0] OFS_STATUS     = 16'h0010;
  localparam logic [15:0] OFS_IRQ_MASK   = 16'h0014;
  localparam logic [15:0] OFS_EVT_CNT0   = 16'h0018;
  localparam logic [15:0] OFS_EVT_CNT1   = 16'h001C;
  localparam logic [15:0] OFS_EVT_CNT2   = 16'h0020;
  localparam logic [15:0] OFS_EVT_CNT3   = 16'h0024;

  localparam int unsigned CTRL_ENABLE_BIT  = 0;
  localparam int unsigned CTRL_CNT_CLR_BIT = 1;
  localparam int unsigned CTRL_MODE_LSB    = 4;
  localparam int unsigned CTRL_MODE_W      = 4;

  typedef enum logic [3:0] {
    REG_VERSION,
    REG_SCRATCH,
    REG_CTRL,
    REG_LED_PERIOD,
    REG_STATUS,
    REG_IRQ_MASK,
    REG_EVT_CNT0,
    REG_EVT_CNT1,
    REG_EVT_CNT2,
    REG_EVT_CNT3,
    REG_NONE
  } reg_sel_e;

  // Word-aligned decode; the two byte-lane bits are masked off.
  function automatic reg_sel_e decode_addr(input logic [15:0] addr);
    logic [15:0] ofs;
    ofs = addr & 16'hFFFC;
    case (ofs)
      OFS_VERSION:    return REG_VERSION;
      OFS_SCRATCH:    return REG_SCRATCH;
      OFS_CTRL:       return REG_CTRL;
      OFS_LED_PERIOD: return REG_LED_PERIOD;
      OFS_STATUS:     return REG_STATUS;
      OFS_IRQ_MASK:   return REG_IRQ_MASK;
      OFS_EVT_CNT0:   return REG_EVT_CNT0;
      OFS_EVT_CNT1:   return REG_EVT_CNT1;
      OFS_EVT_CNT2:   return REG_EVT_CNT2;
      OFS_EVT_CNT3:   return REG_EVT_CNT3;
      default:        return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lbs_strobe_edge.sv
`timescale 1ns/1ps
// Falling-edge detector for the active-low local-bus strobes: one pulse per access.
module lbs_strobe_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cs_n,
  input  logic i_we_n,
  input  logic i_rd_n,
  output logic o_wr_stb,
  output logic o_rd_stb
);

  logic r_we_dly;
  logic r_rd_dly;

  // Previous-cycle strobe levels; reset high so only a real falling edge fires.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we_dly <= 1'b1;
      r_rd_dly <= 1'b1;
    end else begin
      r_we_dly <= i_we_n;
      r_rd_dly <= i_rd_n;
    end
  end

  assign o_wr_stb = ~i_cs_n & r_we_dly & ~i_we_n;
  assign o_rd_stb = ~i_cs_n & r_rd_dly & ~i_rd_n;

endmodule

// File: rtl/lbs_wave_regs.sv
`timescale 1ns/1ps
// Wave-path control/status register slave behind the AXI4-lite bridge.
module lbs_wave_regs
  import lbs_wave_regs_pkg::*;
#(
  parameter int          U_DLY          = 1,
  parameter logic [31:0] VERSION        = 32'h2014_0100,
  parameter logic [31:0] LED_PERIOD_RST = 32'd50_000_000
) (
  input  logic             axi4_lite_clk,
  input  logic             rst_n,
  input  logic [15:0]      cpu_addr,
  input  logic             cpu_cs,
  input  logic             cpu_we,
  input  logic             cpu_rd,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  input  logic [N_EVT-1:0] evt_in,
  output logic             ctrl_enable,
  output logic [3:0]       ctrl_mode,
  output logic             led_pulse,
  output logic             irq
);

  // U_DLY is kept only so existing instantiations still elaborate; no delays are modelled.

  logic             w_wr_stb;
  logic             w_rd_stb;
  reg_sel_e         w_sel;
  logic             w_cnt_clr;
  logic             w_wr_period;
  logic [N_EVT-1:0] w_w1c;
  logic [31:0]      w_led_max;
  logic [31:0]      w_rdata;
  logic [31:0]      w_evt_cnt [N_EVT];

  logic [31:0]      r_scratch;
  logic             r_ctrl_en;
  logic [3:0]       r_ctrl_mode;
  logic [31:0]      r_led_period;
  logic [N_EVT-1:0] r_status;
  logic [N_EVT-1:0] r_irq_mask;
  logic             r_irq;
  logic [31:0]      r_rdata;
  logic [31:0]      r_led_cnt;
  logic             r_led_pulse;

  lbs_strobe_edge u_strobe_edge (
    .i_clk    (axi4_lite_clk),
    .i_rst_n  (rst_n),
    .i_cs_n   (cpu_cs),
    .i_we_n   (cpu_we),
    .i_rd_n   (cpu_rd),
    .o_wr_stb (w_wr_stb),
    .o_rd_stb (w_rd_stb)
  );

  assign w_sel       = decode_addr(cpu_addr);
  assign w_cnt_clr   = w_wr_stb & (w_sel == REG_CTRL) & cpu_wdata[CTRL_CNT_CLR_BIT];
  assign w_wr_period = w_wr_stb & (w_sel == REG_LED_PERIOD);
  assign w_w1c       = (w_wr_stb && (w_sel == REG_STATUS)) ? cpu_wdata[N_EVT-1:0] : '0;
  assign w_led_max   = (r_led_period == '0) ? '0 : r_led_period - 32'd1;

  // Plain RW registers committed on the write strobe.
  always_ff @(posedge axi4_lite_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scratch    <= '0;
      r_ctrl_en    <= 1'b0;
      r_ctrl_mode  <= '0;
      r_led_period <= LED_PERIOD_RST;
      r_irq_mask   <= '0;
    end else if (w_wr_stb) begin
      case (w_sel)
        REG_SCRATCH:    r_scratch    <= cpu_wdata;
        REG_CTRL: begin
          r_ctrl_en   <= cpu_wdata[CTRL_ENABLE_BIT];
          r_ctrl_mode <= cpu_wdata[CTRL_MODE_LSB +: CTRL_MODE_W];
        end
        REG_LED_PERIOD: r_led_period <= cpu_wdata;
        REG_IRQ_MASK:   r_irq_mask   <= cpu_wdata[N_EVT-1:0];
        default: ;
      endcase
    end
  end

  // Sticky event flags; a new event outranks a coincident W1C.
  always_ff @(posedge axi4_lite_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_w1c) | evt_in;
    end
  end

  // Level interrupt from the registered flags and mask.
  always_ff @(posedge axi4_lite_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_status & r_irq_mask);
    end
  end

  // Per-event wrapping counters; cnt_clr outranks a coincident event.
  for (genvar i = 0; i < N_EVT; i++) begin : g_evt
    logic [31:0] r_cnt;
    always_ff @(posedge axi4_lite_clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (evt_in[i]) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
    assign w_evt_cnt[i] = r_cnt;
  end

  // LED heartbeat: toggles every max(LED_PERIOD,1) cycles while enabled.
  always_ff @(posedge axi4_lite_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_cnt   <= '0;
      r_led_pulse <= 1'b0;
    end else if (!r_ctrl_en) begin
      r_led_cnt   <= '0;
      r_led_pulse <= 1'b0;
    end else if (w_wr_period) begin
      r_led_cnt   <= '0;
    end else if (r_led_cnt == w_led_max) begin
      r_led_cnt   <= '0;
      r_led_pulse <= ~r_led_pulse;
    end else begin
      r_led_cnt   <= r_led_cnt + 32'd1;
    end
  end

  // Read-data mux over current (pre-update) register values.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_VERSION:    w_rdata = VERSION;
      REG_SCRATCH:    w_rdata = r_scratch;
      REG_CTRL: begin
        w_rdata[CTRL_ENABLE_BIT]                = r_ctrl_en;
        w_rdata[CTRL_MODE_LSB +: CTRL_MODE_W]   = r_ctrl_mode;
      end
      REG_LED_PERIOD: w_rdata = r_led_period;
      REG_STATUS:     w_rdata[N_EVT-1:0] = r_status;
      REG_IRQ_MASK:   w_rdata[N_EVT-1:0] = r_irq_mask;
      REG_EVT_CNT0:   w_rdata = w_evt_cnt[0];
      REG_EVT_CNT1:   w_rdata = w_evt_cnt[1];
      REG_EVT_CNT2:   w_rdata = w_evt_cnt[2];
      REG_EVT_CNT3:   w_rdata = w_evt_cnt[3];
      default:        w_rdata = '0;
    endcase
  end

  // Read data captured once per read access and held until the next one.
  always_ff @(posedge axi4_lite_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_rd_stb) begin
      r_rdata <= w_rdata;
    end
  end

  assign cpu_rdata   = r_rdata;
  assign ctrl_enable = r_ctrl_en;
  assign ctrl_mode   = r_ctrl_mode;
  assign led_pulse   = r_led_pulse;
  assign irq         = r_irq;

endmodule

// File: tb/tb_lbs_wave_regs.sv
`timescale 1ns/1ps
// Directed self-checking bench for lbs_wave_regs.
module tb_lbs_wave_regs;
  import lbs_wave_regs_pkg::*;

  localparam logic [31:0] VER  = 32'h2014_0100;
  localparam logic [31:0] LEDR = 32'd50_000_000;

  logic        axi4_lite_clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_cs;
  logic        cpu_we;
  logic        cpu_rd;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic [3:0]  evt_in;
  logic        ctrl_enable;
  logic [3:0]  ctrl_mode;
  logic        led_pulse;
  logic        irq;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned wr_commits = 0;

  lbs_wave_regs #(
    .U_DLY          (1),
    .VERSION        (VER),
    .LED_PERIOD_RST (LEDR)
  ) dut (
    .axi4_lite_clk (axi4_lite_clk),
    .rst_n         (rst_n),
    .cpu_addr      (cpu_addr),
    .cpu_cs        (cpu_cs),
    .cpu_we        (cpu_we),
    .cpu_rd        (cpu_rd),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .evt_in        (evt_in),
    .ctrl_enable   (ctrl_enable),
    .ctrl_mode     (ctrl_mode),
    .led_pulse     (led_pulse),
    .irq           (irq)
  );

  always #5 axi4_lite_clk = ~axi4_lite_clk;

  always @(posedge axi4_lite_clk) if (dut.w_wr_stb === 1'b1) wr_commits++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data,
                           input int unsigned hold, input logic [3:0] evt);
    @(negedge axi4_lite_clk);
    cpu_addr = addr; cpu_wdata = data; cpu_cs = 1'b0; cpu_we = 1'b0; evt_in = evt;
    @(negedge axi4_lite_clk);
    evt_in = '0;
    for (int unsigned i = 1; i < hold; i++) @(negedge axi4_lite_clk);
    cpu_we = 1'b1; cpu_cs = 1'b1;
    @(negedge axi4_lite_clk);
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic [3:0] evt,
                          output logic [31:0] data);
    @(negedge axi4_lite_clk);
    cpu_addr = addr; cpu_cs = 1'b0; cpu_rd = 1'b0; evt_in = evt;
    @(negedge axi4_lite_clk);
    evt_in = '0;
    data = cpu_rdata;
    @(negedge axi4_lite_clk);
    cpu_rd = 1'b1; cpu_cs = 1'b1;
    @(negedge axi4_lite_clk);
  endtask

  task automatic pulse_evt(input logic [3:0] evt);
    @(negedge axi4_lite_clk);
    evt_in = evt;
    @(negedge axi4_lite_clk);
    evt_in = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; cpu_addr = '0; cpu_cs = 1'b1; cpu_we = 1'b1; cpu_rd = 1'b1;
    cpu_wdata = '0; evt_in = '0;
    repeat (3) @(negedge axi4_lite_clk);
    n_tests++;
    if ({led_pulse, irq, ctrl_enable, ctrl_mode} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required 0000000", {led_pulse, irq, ctrl_enable, ctrl_mode});
    end
    n_tests++;
    if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", cpu_rdata); end
    rst_n = 1'b1;
    bus_read(OFS_VERSION, 4'h0, d);
    n_tests++;
    if (d !== VER) begin n_fail++; $display("FAIL reset_version: got %h required %h", d, VER); end
    bus_read(OFS_LED_PERIOD, 4'h0, d);
    n_tests++;
    if (d !== LEDR) begin n_fail++; $display("FAIL reset_led_period: got %h required %h", d, LEDR); end
    bus_read(OFS_CTRL, 4'h0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0", d); end
    bus_read(16'h002C, 4'h0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_unmapped: got %h required 0", d); end
  endtask

  task automatic test_scratch();
    logic [31:0] d;
    wr_commits = 0;
    bus_write(OFS_SCRATCH, 32'hA5A5_5A5A, 5, 4'h0);
    n_tests++;
    if (wr_commits !== 1) begin n_fail++; $display("FAIL scratch_one_commit: got %0d required 1", wr_commits); end
    bus_read(OFS_SCRATCH, 4'h0, d);
    n_tests++;
    if (d !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL scratch_readback: got %h required a5a55a5a", d); end
    bus_write(OFS_VERSION, 32'hDEAD_BEEF, 2, 4'h0);
    bus_read(OFS_VERSION, 4'h0, d);
    n_tests++;
    if (d !== VER) begin n_fail++; $display("FAIL version_ro: got %h required %h", d, VER); end
    bus_write(16'h0040, 32'h1111_2222, 2, 4'h0);
    bus_read(16'h0040, 4'h0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_write: got %h required 0", d); end
  endtask

  task automatic test_events();
    logic [31:0] d;
    repeat (3) pulse_evt(4'b0100);
    bus_read(OFS_EVT_CNT2, 4'h0, d);
    n_tests++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL evt_cnt2: got %h required 3", d); end
    bus_read(OFS_STATUS, 4'h0, d);
    n_tests++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL status_sticky: got %h required 4", d); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b required 0", irq); end
    bus_write(OFS_IRQ_MASK, 32'h4, 2, 4'h0);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b required 1", irq); end
    bus_write(OFS_STATUS, 32'h4, 2, 4'h0);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_w1c: got %b required 0", irq); end
    bus_read(OFS_STATUS, 4'h0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL status_w1c: got %h required 0", d); end
    bus_write(OFS_STATUS, 32'h4, 2, 4'b0100);
    bus_read(OFS_STATUS, 4'h0, d);
    n_tests++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL status_set_wins: got %h required 4", d); end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins: got %b required 1", irq); end
    bus_read(OFS_EVT_CNT2, 4'h0, d);
    n_tests++;
    if (d !== 32'd4) begin n_fail++; $display("FAIL evt_cnt2_w1c_cycle: got %h required 4", d); end
  endtask

  task automatic test_counters();
    logic [31:0] d;
    @(negedge axi4_lite_clk);
    force dut.g_evt[0].r_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.g_evt[0].r_cnt;
    bus_read(OFS_EVT_CNT0, 4'h0, d);
    n_tests++;
    if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL evt_cnt0_preload: got %h required ffffffff", d); end
    pulse_evt(4'b0001);
    bus_read(OFS_EVT_CNT0, 4'h0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL evt_cnt0_wrap: got %h required 0", d); end
    repeat (2) pulse_evt(4'b0010);
    bus_read(OFS_EVT_CNT1, 4'h0, d);
    n_tests++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL evt_cnt1: got %h required 2", d); end
    bus_write(OFS_CTRL, 32'h2, 2, 4'b0010);
    bus_read(OFS_EVT_CNT1, 4'h0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL clr_wins: got %h required 0", d); end
    bus_read(OFS_EVT_CNT2, 4'h0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL clr_all: got %h required 0", d); end
    bus_read(OFS_CTRL, 4'h0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL cnt_clr_reads0: got %h required 0", d); end
    bus_read(OFS_EVT_CNT2, 4'b0100, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL read_pre_update: got %h required 0", d); end
    bus_read(OFS_EVT_CNT2, 4'h0, d);
    n_tests++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL read_post_update: got %h required 1", d); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d;
    bus_write(OFS_CTRL, 32'hFFFF_FFF1, 2, 4'h0);
    bus_read(OFS_CTRL, 4'h0, d);
    n_tests++;
    if (d !== 32'h0000_00F1) begin n_fail++; $display("FAIL ctrl_readback: got %h required 000000f1", d); end
    n_tests++;
    if ({ctrl_enable, ctrl_mode} !== 5'b11111) begin
      n_fail++; $display("FAIL ctrl_outputs: got %b required 11111", {ctrl_enable, ctrl_mode});
    end
    bus_write(OFS_CTRL, 32'h0, 2, 4'h0);
    n_tests++;
    if ({ctrl_enable, ctrl_mode, led_pulse} !== 6'b0) begin
      n_fail++; $display("FAIL ctrl_cleared: got %b required 000000", {ctrl_enable, ctrl_mode, led_pulse});
    end
  endtask

  task automatic test_led();
    logic        prev;
    int unsigned nchg;
    int unsigned t0;
    int unsigned t1;
    bus_write(OFS_LED_PERIOD, 32'd4, 2, 4'h0);
    bus_write(OFS_CTRL, 32'h1, 2, 4'h0);
    prev = led_pulse; nchg = 0; t0 = 0; t1 = 0;
    for (int unsigned c = 1; c <= 40 && nchg < 3; c++) begin
      @(negedge axi4_lite_clk);
      if (led_pulse !== prev) begin
        nchg++;
        if (nchg == 2) t0 = c;
        if (nchg == 3) t1 = c;
        prev = led_pulse;
      end
    end
    n_tests++;
    if (nchg !== 3 || (t1 - t0) !== 4) begin
      n_fail++; $display("FAIL led_period4: got %0d toggles interval %0d required 3 toggles interval 4", nchg, t1 - t0);
    end
    bus_write(OFS_LED_PERIOD, 32'd0, 2, 4'h0);
    prev = led_pulse; nchg = 0;
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge axi4_lite_clk);
      if (led_pulse !== prev) nchg++;
      prev = led_pulse;
    end
    n_tests++;
    if (nchg !== 4) begin n_fail++; $display("FAIL led_period0: got %0d toggles in 4 cycles required 4", nchg); end
    bus_write(OFS_CTRL, 32'h0, 2, 4'h0);
    n_tests++;
    if (led_pulse !== 1'b0) begin n_fail++; $display("FAIL led_disable: got %b required 0", led_pulse); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    bus_write(OFS_SCRATCH, 32'h0000_1234, 2, 4'h0);
    bus_write(OFS_IRQ_MASK, 32'h8, 2, 4'h0);
    pulse_evt(4'b1000);
    bus_write(OFS_CTRL, 32'h1, 2, 4'h0);
    n_tests++;
    if ({irq, ctrl_enable} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_state: got %b required 11", {irq, ctrl_enable}); end
    @(negedge axi4_lite_clk);
    cpu_addr = OFS_SCRATCH; cpu_wdata = 32'h0000_5678; cpu_cs = 1'b0; cpu_we = 1'b0;
    @(negedge axi4_lite_clk);
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({irq, ctrl_enable, led_pulse} !== 3'b000) begin
      n_fail++; $display("FAIL reset_async: got %b required 000", {irq, ctrl_enable, led_pulse});
    end
    @(negedge axi4_lite_clk);
    cpu_we = 1'b1; cpu_cs = 1'b1;
    @(negedge axi4_lite_clk);
    rst_n = 1'b1;
    @(negedge axi4_lite_clk);
    n_tests++;
    if ($isunknown({cpu_rdata, ctrl_enable, ctrl_mode, led_pulse, irq}) !== 1'b0) begin
      n_fail++; $display("FAIL no_x_after_reset: got X on outputs required known");
    end
    bus_read(OFS_SCRATCH, 4'h0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL scratch_after_reset: got %h required 0", d); end
    bus_read(OFS_IRQ_MASK, 4'h0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mask_after_reset: got %h required 0", d); end
    n_tests++;
    if ({irq, ctrl_enable} !== 2'b00) begin n_fail++; $display("FAIL outs_after_reset: got %b required 00", {irq, ctrl_enable}); end
  endtask

  initial begin
    test_reset();
    test_scratch();
    test_events();
    test_counters();
    test_ctrl();
    test_led();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
